// File: rtl/lector_uart.sv
// lector_uart: register-bus reader for the UART receive side.
// Polls the UART control register, reads the data register when a new byte
// is flagged, clears the flag with a write-back, then hands the byte to a
// consumer over a valid/ready handshake. The byte counter wraps at 255.
module lector_uart (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic        addr_o,
    output logic        we_o,
    output logic [31:0] wr_data_o,
    input  logic [31:0] rd_data_i,
    output logic [7:0]  dato_o,
    output logic        dato_valido_o,
    input  logic        dato_listo_i,
    output logic [7:0]  cuenta_o,
    output logic        ocupado_o
);

    // Control register bit positions
    localparam int BIT_SEND   = 0;
    localparam int BIT_NEW_RX = 1;

    typedef enum logic [2:0] {
        REPOSO,
        SONDEO,
        EVALUA,
        LEE_DATO,
        CAPTURA,
        LIMPIA,
        ENTREGA
    } estado_t;

    estado_t estado, estado_sig;

    // Send bit seen in the last control read; written back unchanged when
    // clearing new_rx so an in-flight transmission is not disturbed.
    logic ctrl_send;

    // Handshake completes when the consumer is ready while a byte is shown
    logic acepta;

    // Only the low byte of data reads and the two flag bits of control
    // reads carry meaning; the rest of the read bus is intentionally dropped.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_data_i[31:8], rd_data_i[7:2]};

    assign acepta    = (estado == ENTREGA) && dato_listo_i;
    assign ocupado_o = (estado != REPOSO);

    // State register; async reset returns to idle, which also kills any
    // write strobe of an interrupted transaction immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) estado <= REPOSO;
        else          estado <= estado_sig;
    end

    // Next-state and bus/handshake outputs, decoded from the current state
    always_comb begin
        estado_sig    = estado;
        addr_o        = 1'b0;
        we_o          = 1'b0;
        wr_data_o     = 32'h0;
        dato_valido_o = 1'b0;
        unique case (estado)
            REPOSO: begin
                if (en_i) estado_sig = SONDEO;
            end
            SONDEO: begin
                // control register address presented; result arrives next cycle
                estado_sig = EVALUA;
            end
            EVALUA: begin
                if (rd_data_i[BIT_NEW_RX]) estado_sig = LEE_DATO;
                else if (en_i)             estado_sig = SONDEO;
                else                       estado_sig = REPOSO;
            end
            LEE_DATO: begin
                addr_o     = 1'b1;
                estado_sig = CAPTURA;
            end
            CAPTURA: begin
                estado_sig = LIMPIA;
            end
            LIMPIA: begin
                we_o       = 1'b1;
                wr_data_o  = {30'b0, 1'b0, ctrl_send};
                estado_sig = ENTREGA;
            end
            ENTREGA: begin
                dato_valido_o = 1'b1;
                if (dato_listo_i) estado_sig = en_i ? SONDEO : REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // Latch the send bit from the control read being evaluated
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)               ctrl_send <= 1'b0;
        else if (estado == EVALUA)  ctrl_send <= rd_data_i[BIT_SEND];
    end

    // Capture the received byte; it stays put through any backpressure
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)               dato_o <= 8'h00;
        else if (estado == CAPTURA) dato_o <= rd_data_i[7:0];
    end

    // Delivered-byte counter, wrapping naturally at 8 bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    cuenta_o <= 8'h00;
        else if (acepta) cuenta_o <= cuenta_o + 8'd1;
    end

endmodule

// File: tb/tb_lector_uart.sv
// Directed self-checking bench for lector_uart. A small registered UART
// register-file model answers reads and logs write-backs.
module tb_lector_uart;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic        addr_o;
    logic        we_o;
    logic [31:0] wr_data_o;
    logic [31:0] rd_data_i = 32'h0;
    logic [7:0]  dato_o;
    logic        dato_valido_o;
    logic        dato_listo_i;
    logic [7:0]  cuenta_o;
    logic        ocupado_o;

    // Register contents as set by the stimulus
    logic [31:0] ctrl_val;
    logic [31:0] data_val;

    // Write-back log
    int          wr_cnt = 0;
    logic [31:0] last_wr = 32'h0;
    logic        last_wr_addr = 1'b0;

    int checks = 0;
    int errors = 0;

    lector_uart dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .addr_o       (addr_o),
        .we_o         (we_o),
        .wr_data_o    (wr_data_o),
        .rd_data_i    (rd_data_i),
        .dato_o       (dato_o),
        .dato_valido_o(dato_valido_o),
        .dato_listo_i (dato_listo_i),
        .cuenta_o     (cuenta_o),
        .ocupado_o    (ocupado_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered-read UART register file; records every write strobe
    always @(posedge clk_i) begin
        rd_data_i <= addr_o ? data_val : ctrl_val;
        if (we_o) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr      <= wr_data_o;
            last_wr_addr <= addr_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    // One full receive transaction starting from REPOSO at a falling edge
    task automatic deliver(input logic [31:0] ctrl, input logic [31:0] data,
                           input logic [31:0] exp_wr, input logic [7:0] exp_dato,
                           input int stall, input logic en_after);
        int          wr0;
        logic [7:0]  cnt0;
        logic [7:0]  cnt1;
        wr0          = wr_cnt;
        cnt0         = cuenta_o;
        cnt1         = cnt0 + 8'd1;
        ctrl_val     = ctrl;
        data_val     = data;
        en_i         = 1'b1;
        dato_listo_i = (stall == 0);
        nxt(); // SONDEO
        chk("sondeo_ocupado", {31'b0, ocupado_o}, 1);
        chk("sondeo_addr", {31'b0, addr_o}, 0);
        chk("sondeo_valido", {31'b0, dato_valido_o}, 0);
        nxt(); // EVALUA
        chk("evalua_addr", {31'b0, addr_o}, 0);
        chk("evalua_valido", {31'b0, dato_valido_o}, 0);
        nxt(); // LEE_DATO
        chk("lee_addr", {31'b0, addr_o}, 1);
        chk("lee_we", {31'b0, we_o}, 0);
        nxt(); // CAPTURA
        chk("captura_addr", {31'b0, addr_o}, 0);
        chk("captura_we", {31'b0, we_o}, 0);
        chk("captura_valido", {31'b0, dato_valido_o}, 0);
        nxt(); // LIMPIA
        chk("limpia_we", {31'b0, we_o}, 1);
        chk("limpia_addr", {31'b0, addr_o}, 0);
        chk("limpia_wr_data", wr_data_o, exp_wr);
        chk("limpia_valido", {31'b0, dato_valido_o}, 0);
        ctrl_val = 32'h0;
        en_i     = en_after;
        nxt(); // ENTREGA
        chk("entrega_valido", {31'b0, dato_valido_o}, 1);
        chk("entrega_dato", {24'b0, dato_o}, {24'b0, exp_dato});
        chk("entrega_we", {31'b0, we_o}, 0);
        chk("entrega_wr_data", wr_data_o, 0);
        chk("one_write", wr_cnt, wr0 + 1);
        chk("write_value", last_wr, exp_wr);
        chk("write_addr", {31'b0, last_wr_addr}, 0);
        chk("cuenta_before", {24'b0, cuenta_o}, {24'b0, cnt0});
        for (int i = 0; i < stall; i++) begin
            nxt();
            chk("stall_valido", {31'b0, dato_valido_o}, 1);
            chk("stall_dato", {24'b0, dato_o}, {24'b0, exp_dato});
            chk("stall_bus", {30'b0, we_o, addr_o}, 0);
            chk("stall_cuenta", {24'b0, cuenta_o}, {24'b0, cnt0});
        end
        chk("stall_no_write", wr_cnt, wr0 + 1);
        dato_listo_i = 1'b1;
        nxt(); // handshake done
        chk("post_valido", {31'b0, dato_valido_o}, 0);
        chk("post_cuenta", {24'b0, cuenta_o}, {24'b0, cnt1});
        chk("post_ocupado", {31'b0, ocupado_o}, {31'b0, en_after});
        en_i         = 1'b0;
        dato_listo_i = 1'b0;
        nxt();
        nxt();
        chk("back_to_idle", {31'b0, ocupado_o}, 0);
    endtask

    initial begin
        int pulses;
        int wr_base;
        rst_n_i      = 1'b0;
        en_i         = 1'b0;
        dato_listo_i = 1'b0;
        ctrl_val     = 32'h0;
        data_val     = 32'h0;

        // Reset state
        nxt();
        chk("rst_addr", {31'b0, addr_o}, 0);
        chk("rst_we", {31'b0, we_o}, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_dato", {24'b0, dato_o}, 0);
        chk("rst_valido", {31'b0, dato_valido_o}, 0);
        chk("rst_cuenta", {24'b0, cuenta_o}, 0);
        chk("rst_ocupado", {31'b0, ocupado_o}, 0);

        // Reset arriving in the middle of the clear write
        rst_n_i  = 1'b1;
        en_i     = 1'b1;
        ctrl_val = 32'h2;
        data_val = 32'h11;
        repeat (5) nxt();
        chk("mid_limpia_we", {31'b0, we_o}, 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_we", {31'b0, we_o}, 0);
        chk("async_wr_data", wr_data_o, 0);
        chk("async_ocupado", {31'b0, ocupado_o}, 0);
        chk("async_dato", {24'b0, dato_o}, 0);
        chk("async_addr", {31'b0, addr_o}, 0);
        en_i     = 1'b0;
        ctrl_val = 32'h0;
        nxt();
        rst_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("idle_after_rst", {29'b0, ocupado_o, we_o, addr_o}, 0);
        end
        chk("no_write_after_rst", wr_cnt, 0);

        // Idle polling: no byte pending
        en_i         = 1'b1;
        dato_listo_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nxt();
            chk("poll_bus", {30'b0, we_o, addr_o}, 0);
            chk("poll_valido", {31'b0, dato_valido_o}, 0);
            chk("poll_ocupado", {31'b0, ocupado_o}, 1);
            chk("poll_cuenta", {24'b0, cuenta_o}, 0);
        end
        chk("poll_no_write", wr_cnt, 0);
        en_i = 1'b0;
        nxt();
        nxt();
        chk("poll_stop", {31'b0, ocupado_o}, 0);

        // Single bytes, then a byte under backpressure with polling resuming
        deliver(32'h0000_0002, 32'hFFFF_FF5A, 32'h0000_0000, 8'h5A, 0, 1'b0);
        chk("cuenta_1", {24'b0, cuenta_o}, 1);
        deliver(32'h0000_0003, 32'h0000_00A7, 32'h0000_0001, 8'hA7, 0, 1'b0);
        deliver(32'h0000_0002, 32'h0000_003C, 32'h0000_0000, 8'h3C, 20, 1'b1);
        chk("cuenta_3", {24'b0, cuenta_o}, 3);

        // 256 back-to-back bytes; en_i dropped during the last LEE_DATO
        rst_n_i = 1'b0;
        nxt();
        rst_n_i      = 1'b1;
        chk("rst2_cuenta", {24'b0, cuenta_o}, 0);
        wr_base      = wr_cnt;
        pulses       = 0;
        data_val     = 32'h0;
        ctrl_val     = 32'h2;
        en_i         = 1'b1;
        dato_listo_i = 1'b1;
        for (int c = 0; c < 2000 && pulses < 256; c++) begin
            nxt();
            if (dato_valido_o) begin
                chk("burst_dato", {24'b0, dato_o}, pulses & 32'hFF);
                pulses++;
                data_val = pulses;
            end
            if (pulses == 255 && addr_o) en_i = 1'b0;
        end
        chk("burst_count", pulses, 256);
        chk("burst_writes", wr_cnt - wr_base, 256);
        chk("burst_cuenta_last", {24'b0, cuenta_o}, 32'hFF);
        nxt();
        chk("wrap_cuenta", {24'b0, cuenta_o}, 0);
        chk("wrap_idle", {31'b0, ocupado_o}, 0);
        chk("wrap_valido", {31'b0, dato_valido_o}, 0);
        nxt();
        chk("wrap_stays_idle", {31'b0, ocupado_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
